branch_ctrl: RTL and testbench
==============================

// Module: branch_ctrl
// PURPOSE
//  Sequencer stage downstream of the logic/compare unit in the 16-bit controller.
//  - Holds the 16-bit status flag register loaded from the compare unit's flag output.
//  - Returns the registered flags as that unit's flag input.
//  - Owns the program counter: sequential step, JMP, conditional jump on compare flags, CALL/RET via a hardware return stack.
//  Flag bits: [9]=EQ, [8]=GT, [7]=LT. All other bits are carried unchanged.
// PARAMETERS
//  STACK_DEPTH  8        return-stack entries (power of 2, 2..16)
//  PC_RESET     16'h0000 PC value after reset
// PORTS
//  CLK        in   1   clock, rising edge
//  RST_N      in   1   asynchronous reset, active-low
//  FLAG_WE    in   1   load FLAG_IN into the flag register
//  FLAG_IN    in   16  flags from the compare unit
//  FLAG_OUT   out  16  registered flags; fed back to the compare unit
//  BR_VALID   in   1   BR_OP/BR_COND/BR_TARGET are valid this cycle
//  BR_OP      in   3   000 SEQ, 001 JMP, 010 JCOND, 011 CALL, 100 RET, others=SEQ
//  BR_COND    in   3   000 EQ, 001 NE, 010 GT, 011 LE, 100 LT, 101 GE, 110 ALWAYS, 111 NEVER
//  BR_TARGET  in   16  jump/call destination
//  STALL      in   1   freeze PC and ignore the branch request
//  PC         out  16  current program counter
//  BR_TAKEN   out  1   one-cycle pulse: the last PC update was non-sequential
//  STK_DEPTH  out  5   current number of return-stack entries
//  STK_ERR    out  1   sticky: CALL issued when the stack was full, or RET when it was empty
// BEHAVIOUR
//  - Reset (RST_N=0, asynchronous): PC=PC_RESET; FLAG_OUT=0; BR_TAKEN=0; STK_DEPTH=0; STK_ERR=0.
//    A reset asserted mid-operation discards the stack contents and any pending branch.
//  - Flag register: if FLAG_WE=1 at the clock edge, FLAG_OUT <= FLAG_IN. STALL does not block the load.
//  - Condition evaluation on flags F:
//      EQ = F[9];  NE = !F[9];  GT = F[8];  LT = F[7];
//      LE = F[9] | F[7];  GE = F[9] | F[8];  ALWAYS = 1;  NEVER = 0.
//  - Next-PC rule, applied only when STALL=0 (when STALL=1, PC holds and BR_TAKEN=0):
//      no BR_VALID, or SEQ  -> PC+1
//      JMP                   -> BR_TARGET
//      JCOND                 -> BR_TARGET if the condition is true, else PC+1
//      CALL                  -> push PC+1, then BR_TARGET
//      RET                   -> pop; PC = popped value
//  - Latency: a request sampled at edge N produces the new PC and BR_TAKEN at edge N, visible in cycle N+1.
//    BR_TAKEN is high for exactly one cycle.
//  - PC arithmetic is modulo 2^16: 16'hFFFF + 1 wraps to 16'h0000.
//  - Stack boundaries:
//      CALL with STK_DEPTH==STACK_DEPTH -> no push, PC+1, STK_ERR<=1, BR_TAKEN=0.
//      RET with STK_DEPTH==0            -> PC+1, STK_ERR<=1, BR_TAKEN=0.
//    STK_ERR is cleared only by reset.
//  - Only one BR_OP is accepted per cycle. FLAG_WE may coincide with any BR_OP.
// CONFIGURATION
//  Macro BRANCH_CTRL_FLAG_BYPASS_EN:
//  - Defined: JCOND evaluates FLAG_IN when FLAG_WE=1 in the same cycle.
//    A compare followed by a branch in the same cycle therefore resolves with zero delay.
//  - Undefined: JCOND always evaluates the registered FLAG_OUT.
//    The branch must be issued at least one cycle after the compare.
// STRUCTURE
//  - Package branch_ctrl_pkg holds:
//      BR_OP and BR_COND encodings;
//      flag bit indices FLAG_EQ=9, FLAG_GT=8, FLAG_LT=7;
//      the condition-evaluate function.
//  - One sub-module, branch_ctrl_rstack: a LIFO with push/pop/full/empty and a depth count.
//    It has no overflow or underflow side effects; branch_ctrl gates push/pop using full/empty.
// TESTING
//  1. Reset with PC_RESET=16'h0100, then 3 idle cycles -> PC = 0100, 0101, 0102, 0103; BR_TAKEN=0; FLAG_OUT=0.
//  2. FLAG_WE with FLAG_IN=16'h0200, next cycle JCOND EQ target 16'h0040 -> PC=0040, BR_TAKEN pulses once.
//     Same flags with JCOND GT -> PC+1.
//  3. CALL 16'h0200 from PC=16'h0010, then RET -> PC=0200, then 0011; STK_DEPTH goes 1, then 0.
//  4. STACK_DEPTH+1 consecutive CALLs -> final CALL takes PC+1; STK_DEPTH=8; STK_ERR=1.
//     A RET on an empty stack -> PC+1; STK_ERR stays 1.
//  5. FLAG_WE with 16'h0080 and JCOND LT issued in the same cycle, flags previously 0 ->
//     jump taken with BRANCH_CTRL_FLAG_BYPASS_EN defined; not taken without it.
//  6. STALL=1 with JMP 16'h1234 -> PC holds and the FLAG_WE load still lands.
//     PC=16'hFFFF with SEQ -> PC=16'h0000. RST_N pulsed low mid-CALL -> all outputs return to reset values.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_ctrl_pkg
// Shared definitions for the branch/sequencer stage:
//   - branch operation and branch condition encodings
//   - bit positions of the compare flags inside the 16-bit status word
//   - cond_true(): evaluates a branch condition against the EQ/GT/LT flags
// ---------------------------------------------------------------------------
package branch_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_SEQ   = 3'b000,
        OP_JMP   = 3'b001,
        OP_JCOND = 3'b010,
        OP_CALL  = 3'b011,
        OP_RET   = 3'b100
    } br_op_e;

    typedef enum logic [2:0] {
        CC_EQ     = 3'b000,
        CC_NE     = 3'b001,
        CC_GT     = 3'b010,
        CC_LE     = 3'b011,
        CC_LT     = 3'b100,
        CC_GE     = 3'b101,
        CC_ALWAYS = 3'b110,
        CC_NEVER  = 3'b111
    } br_cond_e;

    localparam int FLAG_EQ = 9;
    localparam int FLAG_GT = 8;
    localparam int FLAG_LT = 7;

    function automatic logic cond_true(input br_cond_e cond,
                                       input logic     eq,
                                       input logic     gt,
                                       input logic     lt);
        logic res;
        res = 1'b0;
        case (cond)
            CC_EQ:     res = eq;
            CC_NE:     res = ~eq;
            CC_GT:     res = gt;
            CC_LE:     res = eq | lt;
            CC_LT:     res = lt;
            CC_GE:     res = eq | gt;
            CC_ALWAYS: res = 1'b1;
            CC_NEVER:  res = 1'b0;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/branch_ctrl_rstack.sv
// ---------------------------------------------------------------------------
// branch_ctrl_rstack
// Hardware return-address LIFO. The top entry is presented combinationally
// so a RET can use it in the same cycle it is popped. Push/pop requests that
// would overflow/underflow are simply ignored; the caller decides what an
// overflow means.
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset (empties the stack)
//   push_i       push push_data_i
//   pop_i        drop the top entry
//   push_data_i  value to push
//   top_data_o   current top entry (undefined when empty)
//   full_o       depth == DEPTH
//   empty_o      depth == 0
//   depth_o      number of valid entries
// ---------------------------------------------------------------------------
module branch_ctrl_rstack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [4:0]       depth_o
);
    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_W = 5'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [4:0]       depth_q, depth_d;
    logic [PTR_W-1:0] wr_idx, rd_idx;

    // depth_q doubles as the write pointer; the top entry sits one below it.
    assign wr_idx     = depth_q[PTR_W-1:0];
    assign rd_idx     = PTR_W'(depth_q - 5'd1);
    assign full_o     = (depth_q == DEPTH_W);
    assign empty_o    = (depth_q == 5'd0);
    assign depth_o    = depth_q;
    assign top_data_o = mem_q[rd_idx];

    always_comb begin
        depth_d = depth_q;
        if (push_i && !full_o) begin
            depth_d = depth_q + 5'd1;
        end else if (pop_i && !empty_o) begin
            depth_d = depth_q - 5'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            depth_q <= 5'd0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Storage carries no reset: entries above depth_q are never read.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
// Sequencer stage after the logic/compare unit: holds the status flag
// register and owns the program counter (step, JMP, conditional jump,
// CALL/RET through a hardware return stack).
// Configuration macro: BRANCH_CTRL_FLAG_BYPASS_EN
//   defined   -> JCOND sees flag_in_i when flag_we_i is high that cycle
//   undefined -> JCOND always sees the registered flags
// Ports:
//   clk_i         clock, rising edge
//   rst_n_i       asynchronous active-low reset
//   flag_we_i     load flag_in_i into the flag register
//   flag_in_i     flags from the compare unit
//   flag_out_o    registered flags (fed back to the compare unit)
//   br_valid_i    br_op_i/br_cond_i/br_target_i valid
//   br_op_i       branch operation
//   br_cond_i     branch condition for JCOND
//   br_target_i   jump/call destination
//   stall_i       hold PC and ignore the branch request
//   pc_o          program counter
//   br_taken_o    last PC update was non-sequential (one-cycle pulse)
//   stk_depth_o   return-stack occupancy
//   stk_err_o     sticky overflow/underflow indication
// ---------------------------------------------------------------------------
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int          STACK_DEPTH = 8,
    parameter logic [15:0] PC_RESET    = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        flag_we_i,
    input  logic [15:0] flag_in_i,
    output logic [15:0] flag_out_o,
    input  logic        br_valid_i,
    input  logic [2:0]  br_op_i,
    input  logic [2:0]  br_cond_i,
    input  logic [15:0] br_target_i,
    input  logic        stall_i,
    output logic [15:0] pc_o,
    output logic        br_taken_o,
    output logic [4:0]  stk_depth_o,
    output logic        stk_err_o
);
    logic [15:0] pc_q, pc_d;
    logic [15:0] flag_q, flag_d;
    logic        taken_q, taken_d;
    logic        err_q, err_d;

    logic        push, pop;
    logic [15:0] pc_inc;
    logic [15:0] stk_top;
    logic        stk_full, stk_empty;
    logic        cond_eq, cond_gt, cond_lt, cond_hit;
    br_op_e      op;

    assign pc_inc = pc_q + 16'd1;   // wraps naturally at 16 bits
    assign op     = br_op_e'(br_op_i);

`ifdef BRANCH_CTRL_FLAG_BYPASS_EN
    // Same-cycle compare + branch: forward the incoming flags.
    assign cond_eq = flag_we_i ? flag_in_i[FLAG_EQ] : flag_q[FLAG_EQ];
    assign cond_gt = flag_we_i ? flag_in_i[FLAG_GT] : flag_q[FLAG_GT];
    assign cond_lt = flag_we_i ? flag_in_i[FLAG_LT] : flag_q[FLAG_LT];
`else
    assign cond_eq = flag_q[FLAG_EQ];
    assign cond_gt = flag_q[FLAG_GT];
    assign cond_lt = flag_q[FLAG_LT];
`endif

    assign cond_hit = cond_true(br_cond_e'(br_cond_i), cond_eq, cond_gt, cond_lt);

    always_comb begin
        pc_d    = pc_q;
        taken_d = 1'b0;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        flag_d  = flag_we_i ? flag_in_i : flag_q;   // stall never blocks the load

        if (!stall_i) begin
            pc_d = pc_inc;
            if (br_valid_i) begin
                case (op)
                    OP_JMP: begin
                        pc_d    = br_target_i;
                        taken_d = 1'b1;
                    end
                    OP_JCOND: begin
                        if (cond_hit) begin
                            pc_d    = br_target_i;
                            taken_d = 1'b1;
                        end
                    end
                    OP_CALL: begin
                        if (stk_full) begin
                            err_d = 1'b1;    // falls through to PC+1
                        end else begin
                            push    = 1'b1;
                            pc_d    = br_target_i;
                            taken_d = 1'b1;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            err_d = 1'b1;
                        end else begin
                            pop     = 1'b1;
                            pc_d    = stk_top;
                            taken_d = 1'b1;
                        end
                    end
                    default: ;               // SEQ and unused encodings step
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q    <= PC_RESET;
            flag_q  <= 16'h0000;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            flag_q  <= flag_d;
            taken_q <= taken_d;
            err_q   <= err_d;
        end
    end

    branch_ctrl_rstack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (16)
    ) u_rstack (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_inc),
        .top_data_o  (stk_top),
        .full_o      (stk_full),
        .empty_o     (stk_empty),
        .depth_o     (stk_depth_o)
    );

    assign pc_o       = pc_q;
    assign flag_out_o = flag_q;
    assign br_taken_o = taken_q;
    assign stk_err_o  = err_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_ctrl
// Table-driven bench for branch_ctrl (PC_RESET=16'h0100, STACK_DEPTH=8).
// Each vector is driven one ns after a rising edge; its expected outputs go
// into a scoreboard queue and are popped and compared one ns after the next
// rising edge. Reset behaviour is checked by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_branch_ctrl;

    typedef struct {
        logic        we;
        logic [15:0] fin;
        logic        v;
        logic [2:0]  op;
        logic [2:0]  cond;
        logic [15:0] tgt;
        logic        st;
        logic [15:0] epc;
        logic        etk;
        logic [4:0]  edp;
        logic        eer;
        logic [15:0] efl;
    } vec_t;

    localparam logic [2:0] SEQ = 3'b000, JMP = 3'b001, JCND = 3'b010,
                           CALL = 3'b011, RET = 3'b100;
    localparam logic [2:0] EQ = 3'b000, NE = 3'b001, GT = 3'b010, LE = 3'b011,
                           LT = 3'b100, GE = 3'b101, AL = 3'b110, NV = 3'b111;

`ifdef BRANCH_CTRL_FLAG_BYPASS_EN
    localparam logic [15:0] BYP_PC = 16'h0ABC;
    localparam logic        BYP_TK = 1'b1;
`else
    localparam logic [15:0] BYP_PC = 16'h0015;
    localparam logic        BYP_TK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flag_we;
    logic [15:0] flag_in;
    logic [15:0] flag_out;
    logic        br_valid;
    logic [2:0]  br_op;
    logic [2:0]  br_cond;
    logic [15:0] br_target;
    logic        stall;
    logic [15:0] pc;
    logic        br_taken;
    logic [4:0]  stk_depth;
    logic        stk_err;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    vec_t sb[$];

    branch_ctrl #(
        .STACK_DEPTH (8),
        .PC_RESET    (16'h0100)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .flag_we_i   (flag_we),
        .flag_in_i   (flag_in),
        .flag_out_o  (flag_out),
        .br_valid_i  (br_valid),
        .br_op_i     (br_op),
        .br_cond_i   (br_cond),
        .br_target_i (br_target),
        .stall_i     (stall),
        .pc_o        (pc),
        .br_taken_o  (br_taken),
        .stk_depth_o (stk_depth),
        .stk_err_o   (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic we, input logic [15:0] fin,
                                input logic v, input logic [2:0] op,
                                input logic [2:0] cond, input logic [15:0] tgt,
                                input logic st, input logic [15:0] epc,
                                input logic etk, input logic [4:0] edp,
                                input logic eer, input logic [15:0] efl);
        vec_t r;
        r.we = we; r.fin = fin; r.v = v; r.op = op; r.cond = cond;
        r.tgt = tgt; r.st = st; r.epc = epc; r.etk = etk; r.edp = edp;
        r.eer = eer; r.efl = efl;
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".pc"},    pc,                 16'h0100);
        check({tag, ".taken"}, {15'd0, br_taken},  16'd0);
        check({tag, ".depth"}, {11'd0, stk_depth}, 16'd0);
        check({tag, ".err"},   {15'd0, stk_err},   16'd0);
        check({tag, ".flags"}, flag_out,           16'h0000);
    endtask

    task automatic drive_idle();
        flag_we = 1'b0; flag_in = 16'h0000; br_valid = 1'b0;
        br_op = SEQ; br_cond = EQ; br_target = 16'h0000; stall = 1'b0;
    endtask

    // Called one ns after a rising edge; returns one ns after the next one.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        flag_we = v.we; flag_in = v.fin; br_valid = v.v; br_op = v.op;
        br_cond = v.cond; br_target = v.tgt; stall = v.st;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s.sb: got empty scoreboard expected one entry", tag);
        end else begin
            e = sb.pop_front();
            $display("%s op=%0d cond=%0d tgt=%h -> pc=%h taken=%0d depth=%0d err=%0d flags=%h",
                     tag, v.op, v.cond, v.tgt, pc, br_taken, stk_depth, stk_err, flag_out);
            check({tag, ".pc"},    pc,                 e.epc);
            check({tag, ".taken"}, {15'd0, br_taken},  {15'd0, e.etk});
            check({tag, ".depth"}, {11'd0, stk_depth}, {11'd0, e.edp});
            check({tag, ".err"},   {15'd0, stk_err},   {15'd0, e.eer});
            check({tag, ".flags"}, flag_out,           e.efl);
        end
    endtask

    initial begin
        logic [15:0] ret_pc;

        // ---- vector table ----
        // idle steps from reset
        vecs.push_back(mk(0, 16'h0000, 0, SEQ, EQ, 16'h0000, 0, 16'h0101, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 0, SEQ, EQ, 16'h0000, 0, 16'h0102, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 0, SEQ, EQ, 16'h0000, 0, 16'h0103, 0, 0, 0, 16'h0000));
        // load EQ flag, then conditional jumps on it
        vecs.push_back(mk(1, 16'h0200, 0, SEQ, EQ, 16'h0000, 0, 16'h0104, 0, 0, 0, 16'h0200));
        vecs.push_back(mk(0, 16'h0000, 1, JCND, EQ, 16'h0040, 0, 16'h0040, 1, 0, 0, 16'h0200));
        vecs.push_back(mk(0, 16'h0000, 0, SEQ, EQ, 16'h0000, 0, 16'h0041, 0, 0, 0, 16'h0200));
        vecs.push_back(mk(0, 16'h0000, 1, JCND, GT, 16'h0999, 0, 16'h0042, 0, 0, 0, 16'h0200));
        vecs.push_back(mk(0, 16'h0000, 1, JCND, NE, 16'h0999, 0, 16'h0043, 0, 0, 0, 16'h0200));
        vecs.push_back(mk(0, 16'h0000, 1, JCND, LE, 16'h0500, 0, 16'h0500, 1, 0, 0, 16'h0200));
        vecs.push_back(mk(0, 16'h0000, 1, JCND, NV, 16'h0700, 0, 16'h0501, 0, 0, 0, 16'h0200));
        vecs.push_back(mk(0, 16'h0000, 1, JCND, GE, 16'h0600, 0, 16'h0600, 1, 0, 0, 16'h0200));
        vecs.push_back(mk(0, 16'h0000, 1, JCND, LT, 16'h0999, 0, 16'h0601, 0, 0, 0, 16'h0200));
        vecs.push_back(mk(0, 16'h0000, 1, JCND, AL, 16'h0010, 0, 16'h0010, 1, 0, 0, 16'h0200));
        // CALL / RET pair
        vecs.push_back(mk(0, 16'h0000, 1, CALL, EQ, 16'h0200, 0, 16'h0200, 1, 1, 0, 16'h0200));
        vecs.push_back(mk(0, 16'h0000, 1, RET,  EQ, 16'h0000, 0, 16'h0011, 1, 0, 0, 16'h0200));
        // fill the stack: CALL 3000, 3100 .. 3700 (pushes 0012, 3001 .. 3601)
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(0, 16'h0000, 1, CALL, EQ, 16'h3000 + 16'(i * 16'h100), 0,
                              16'h3000 + 16'(i * 16'h100), 1, 5'(i + 1), 0, 16'h0200));
        end
        // overflow CALL: steps instead, sets sticky error
        vecs.push_back(mk(0, 16'h0000, 1, CALL, EQ, 16'h3800, 0, 16'h3701, 0, 8, 1, 16'h0200));
        // unwind all eight entries in LIFO order
        for (int i = 7; i >= 0; i--) begin
            ret_pc = (i == 0) ? 16'h0012 : 16'h3001 + 16'((i - 1) * 16'h100);
            vecs.push_back(mk(0, 16'h0000, 1, RET, EQ, 16'h0000, 0, ret_pc, 1, 5'(i), 1, 16'h0200));
        end
        // underflow RET
        vecs.push_back(mk(0, 16'h0000, 1, RET, EQ, 16'h0000, 0, 16'h0013, 0, 0, 1, 16'h0200));
        // clear flags, then compare + JCOND LT in the same cycle
        vecs.push_back(mk(1, 16'h0000, 0, SEQ, EQ, 16'h0000, 0, 16'h0014, 0, 0, 1, 16'h0000));
        vecs.push_back(mk(1, 16'h0080, 1, JCND, LT, 16'h0ABC, 0, BYP_PC, BYP_TK, 0, 1, 16'h0080));
        vecs.push_back(mk(0, 16'h0000, 1, JMP, EQ, 16'h0020, 0, 16'h0020, 1, 0, 1, 16'h0080));
        // stall: PC holds, flag load still lands, CALL does not push
        vecs.push_back(mk(1, 16'h0300, 1, JMP, EQ, 16'h1234, 1, 16'h0020, 0, 0, 1, 16'h0300));
        vecs.push_back(mk(0, 16'h0000, 1, CALL, EQ, 16'h0444, 1, 16'h0020, 0, 0, 1, 16'h0300));
        // unused opcode behaves as SEQ
        vecs.push_back(mk(0, 16'h0000, 1, 3'b101, EQ, 16'h0999, 0, 16'h0021, 0, 0, 1, 16'h0300));
        // PC wrap
        vecs.push_back(mk(0, 16'h0000, 1, JMP, EQ, 16'hFFFF, 0, 16'hFFFF, 1, 0, 1, 16'h0300));
        vecs.push_back(mk(0, 16'h0000, 0, SEQ, EQ, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0300));

        // ---- reset ----
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // ---- asynchronous reset during a CALL ----
        apply(mk(1, 16'h0200, 1, CALL, EQ, 16'h0777, 0, 16'h0777, 1, 1, 1, 16'h0200), "pre_rst");
        flag_we = 1'b0; br_valid = 1'b1; br_op = CALL; br_target = 16'h0888;
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        check_reset_state("held_rst");
        drive_idle();
        rst_n = 1'b1;
        apply(mk(0, 16'h0000, 0, SEQ, EQ, 16'h0000, 0, 16'h0101, 0, 0, 0, 16'h0000), "post_rst");
        // stack was discarded: RET underflows
        apply(mk(0, 16'h0000, 1, RET, EQ, 16'h0000, 0, 16'h0102, 0, 0, 1, 16'h0000), "post_rst_ret");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
